// File: rtl/coincidence_trigger_ctrl.sv
// Coincidence trigger controller.
// Opens a coincidence window on the first rising edge of any detector channel,
// ORs further edges into a hit mask for WINDOW cycles, emits an event through a
// valid/ready handshake when enough channels were hit, then waits DEAD_TIME
// cycles. Edges arriving while an event is pending or during dead time are
// counted as drops.
// Optional feature: define TRIG_TIMESTAMP_EN to build the 32-bit free-running
// cycle counter and window-open timestamp; otherwise o_timestamp is tied to 0.
module coincidence_trigger_ctrl #(
    parameter int N_CH      = 4,
    parameter int WINDOW    = 8,
    parameter int DEAD_TIME = 16
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [N_CH-1:0] i_ch,
    input  logic            i_enable,
    input  logic [4:0]      i_min_mult,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [N_CH-1:0] o_mask,
    output logic [31:0]     o_timestamp,
    output logic            o_busy,
    output logic [15:0]     o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WINDOW,
        S_EMIT,
        S_DEAD
    } state_t;

    localparam logic [7:0]  WIN_LOAD  = 8'(WINDOW - 1);
    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_TIME);

    state_t          state;
    logic [N_CH-1:0] ch_d;
    logic [N_CH-1:0] edges;
    logic [N_CH-1:0] mask_acc;
    logic [N_CH-1:0] mask_next;
    logic [7:0]      win_left;
    logic [15:0]     dead_left;
    logic [4:0]      hit_cnt;
    logic [4:0]      min_eff;
    logic            any_edge;
    logic            open_win;
    logic            fire;

    function automatic logic [4:0] popcount(input logic [N_CH-1:0] v);
        logic [4:0] sum;
        sum = 5'd0;
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + 5'(v[i]);
        end
        return sum;
    endfunction

    // Edge detection, window accumulation and trigger decision.
    always_comb begin
        edges     = i_ch & ~ch_d;
        any_edge  = |edges;
        mask_next = mask_acc | edges;
        hit_cnt   = popcount(mask_next);
        // A zero threshold behaves as one; thresholds above N_CH can never be met.
        min_eff   = (i_min_mult == 5'd0) ? 5'd1 : i_min_mult;
        open_win  = (state == S_IDLE) && i_enable && any_edge;
        fire      = (state == S_WINDOW) && i_enable && (win_left == 8'd1) &&
                    (hit_cnt >= min_eff);
    end

    assign o_busy = (state != S_IDLE);

    // Previous-cycle channel levels for rising-edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; reset is synchronous and checked first.
        if (!aresetn) begin
            ch_d <= '0;
        end else begin
            ch_d <= i_ch;
        end
    end

    // Trigger FSM with registered event outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            o_valid   <= 1'b0;
            o_mask    <= '0;
            mask_acc  <= '0;
            win_left  <= '0;
            dead_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (open_win) begin
                        mask_acc <= edges;
                        win_left <= WIN_LOAD;
                        state    <= S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                    end else if (win_left == 8'd1) begin
                        if (fire) begin
                            o_valid <= 1'b1;
                            o_mask  <= mask_next;
                            state   <= S_EMIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        mask_acc <= mask_next;
                        win_left <= win_left - 8'd1;
                    end
                end
                S_EMIT: begin
                    // Event is held regardless of i_enable until accepted.
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        dead_left <= DEAD_LOAD;
                        state     <= S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (dead_left == 16'd1) begin
                        state <= S_IDLE;
                    end else begin
                        dead_left <= dead_left - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of edges seen while an event is pending or in dead time.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            o_drop_cnt <= '0;
        end else if (((state == S_EMIT) || (state == S_DEAD)) && any_edge &&
                     (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] ts_latch;

    // Free-running cycle counter, window-open latch and timestamp output.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cycle_cnt   <= '0;
            ts_latch    <= '0;
            o_timestamp <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (open_win) begin
                ts_latch <= cycle_cnt;
            end
            if (fire) begin
                o_timestamp <= ts_latch;
            end
        end
    end
`else
    assign o_timestamp = 32'd0;
`endif

endmodule

// File: tb/tb_coincidence_trigger_ctrl.sv
// Directed testbench for coincidence_trigger_ctrl (N_CH=4, WINDOW=8,
// DEAD_TIME=16). Inputs are driven and outputs sampled on the falling edge;
// "cyc" tracks the DUT cycle-counter value of the current cycle.
module tb_coincidence_trigger_ctrl;

`ifdef TRIG_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  i_ch = '0;
    logic        i_enable = 1'b1;
    logic [4:0]  i_min_mult = 5'd2;
    logic        i_ready = 1'b1;
    logic        o_valid;
    logic [3:0]  o_mask;
    logic [31:0] o_timestamp;
    logic        o_busy;
    logic [15:0] o_drop_cnt;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    coincidence_trigger_ctrl #(
        .N_CH(4),
        .WINDOW(8),
        .DEAD_TIME(16)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .i_ch(i_ch),
        .i_enable(i_enable),
        .i_min_mult(i_min_mult),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_mask(o_mask),
        .o_timestamp(o_timestamp),
        .o_busy(o_busy),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle number: 0 in the first cycle after reset.
    always @(posedge clk) begin
        if (!aresetn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_cycle: observed cycle %0d expected %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        i_ch    = '0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        check("rst_valid", 32'(o_valid), 0);
        check("rst_mask", 32'(o_mask), 0);
        check("rst_ts", o_timestamp, 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_drop", 32'(o_drop_cnt), 0);

        // ---- two-channel coincidence, immediate accept ----
        i_min_mult = 5'd2; i_ready = 1'b1; i_enable = 1'b1;
        at_cyc(100); i_ch[0] = 1'b1;
        at_cyc(101); check("a_busy_win", 32'(o_busy), 1);
        at_cyc(105); i_ch[2] = 1'b1;
        at_cyc(107); check("a_valid_early", 32'(o_valid), 0);
        at_cyc(108);
        check("a_valid", 32'(o_valid), 1);
        check("a_mask", 32'(o_mask), 32'h5);
        check("a_ts", o_timestamp, TS_EN ? 32'd100 : 32'd0);
        at_cyc(109);
        check("a_valid_done", 32'(o_valid), 0);
        check("a_busy_dead", 32'(o_busy), 1);
        at_cyc(124);
        check("a_busy_dead_last", 32'(o_busy), 1);
        i_ch[1] = 1'b1;
        at_cyc(125);
        check("a_idle", 32'(o_busy), 0);
        check("a_drop_dead_end", 32'(o_drop_cnt), 1);
        i_ch[3] = 1'b1;
        at_cyc(126); check("a_reopen", 32'(o_busy), 1);
        at_cyc(132); check("a_win_last", 32'(o_busy), 1);
        at_cyc(133);
        check("a_single_idle", 32'(o_busy), 0);
        check("a_single_novalid", 32'(o_valid), 0);

        // ---- single channel below threshold ----
        do_reset();
        i_min_mult = 5'd2;
        at_cyc(50); i_ch[1] = 1'b1;
        at_cyc(57); check("b_busy", 32'(o_busy), 1);
        at_cyc(58);
        check("b_idle", 32'(o_busy), 0);
        check("b_novalid", 32'(o_valid), 0);
        check("b_drop", 32'(o_drop_cnt), 0);

        // ---- back-pressure with drops ----
        do_reset();
        i_min_mult = 5'd1; i_ready = 1'b0;
        at_cyc(10); i_ch[3] = 1'b1;
        for (int c = 18; c <= 37; c++) begin
            at_cyc(c);
            check("c_valid_hold", 32'(o_valid), 1);
            check("c_mask_hold", 32'(o_mask), 32'h8);
            if (c == 20 || c == 24 || c == 28) i_ch[0] = 1'b1;
            if (c == 22 || c == 26 || c == 30) i_ch[0] = 1'b0;
        end
        check("c_ts", o_timestamp, TS_EN ? 32'd10 : 32'd0);
        check("c_drop", 32'(o_drop_cnt), 3);
        at_cyc(38); i_ready = 1'b1;
        at_cyc(39);
        check("c_valid_done", 32'(o_valid), 0);
        check("c_busy_dead", 32'(o_busy), 1);
        check("c_drop_final", 32'(o_drop_cnt), 3);

        // ---- abort by i_enable, disabled edges ignored ----
        do_reset();
        i_min_mult = 5'd1; i_ready = 1'b1; i_enable = 1'b1;
        at_cyc(10); i_ch[0] = 1'b1;
        at_cyc(13); check("d_busy", 32'(o_busy), 1);
        i_enable = 1'b0;
        at_cyc(14); check("d_abort", 32'(o_busy), 0);
        at_cyc(16); i_ch[1] = 1'b1;
        at_cyc(18);
        check("d_novalid", 32'(o_valid), 0);
        i_ch[2] = 1'b1;
        at_cyc(20);
        check("d_drop", 32'(o_drop_cnt), 0);
        check("d_idle", 32'(o_busy), 0);
        i_enable = 1'b1;

        // ---- reset during EMIT ----
        do_reset();
        i_min_mult = 5'd1; i_ready = 1'b0;
        at_cyc(10); i_ch[2] = 1'b1;
        at_cyc(20);
        check("e_valid_pre", 32'(o_valid), 1);
        aresetn = 1'b0;
        i_ch = '0;
        @(negedge clk);
        check("e_valid", 32'(o_valid), 0);
        check("e_mask", 32'(o_mask), 0);
        check("e_ts", o_timestamp, 0);
        check("e_busy", 32'(o_busy), 0);
        check("e_drop", 32'(o_drop_cnt), 0);
        aresetn = 1'b1; i_ready = 1'b1;
        at_cyc(5); i_ch[1] = 1'b1;
        at_cyc(13);
        check("e_valid_new", 32'(o_valid), 1);
        check("e_mask_new", 32'(o_mask), 32'h2);
        check("e_ts_new", o_timestamp, TS_EN ? 32'd5 : 32'd0);

        // ---- multiplicity limits ----
        do_reset();
        i_min_mult = 5'd5; i_ready = 1'b1;
        at_cyc(10); i_ch = 4'hF;
        at_cyc(18);
        check("f_over_novalid", 32'(o_valid), 0);
        check("f_over_idle", 32'(o_busy), 0);
        at_cyc(20); i_ch = 4'h0; i_min_mult = 5'd0;
        at_cyc(25); i_ch[1] = 1'b1;
        at_cyc(33);
        check("f_zero_valid", 32'(o_valid), 1);
        check("f_zero_mask", 32'(o_mask), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
